// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: pending/enable/mode registers, priority
// selection of the lowest-index active source and a claim/complete handshake.
module irq_controller #(
    parameter int unsigned NUM_SOURCES  = 8,
    parameter logic [3:0]  PENDING_ADDR = 4'h0,
    parameter logic [3:0]  ENABLE_ADDR  = 4'h4,
    parameter logic [3:0]  MODE_ADDR    = 4'h8,
    parameter logic [3:0]  CLAIM_ADDR   = 4'hC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            address,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            wr_data,
    output logic [31:0]            rd_data,
    input  logic [NUM_SOURCES-1:0] irq_src,
    output logic                   irq_out
);

    localparam int unsigned ID_W = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERT     = 2'd1,
        IN_SERVICE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] enable_q;
    logic [NUM_SOURCES-1:0] mode_q;
    logic [NUM_SOURCES-1:0] src_q;
    logic [ID_W-1:0]        active_id_q, active_id_d;

    logic [NUM_SOURCES-1:0] inservice_mask;
    logic [NUM_SOURCES-1:0] active;
    logic [NUM_SOURCES-1:0] rise;
    logic [NUM_SOURCES-1:0] w1c;
    logic [NUM_SOURCES-1:0] claim_clr;
    logic [ID_W-1:0]        best_id;
    logic                   sel_pending, sel_enable, sel_mode, sel_claim;
    logic                   claim_rd, complete_wr;
    logic                   unused_wr_bits;

    assign sel_pending = (address == {28'h0, PENDING_ADDR});
    assign sel_enable  = (address == {28'h0, ENABLE_ADDR});
    assign sel_mode    = (address == {28'h0, MODE_ADDR});
    assign sel_claim   = (address == {28'h0, CLAIM_ADDR});

    assign unused_wr_bits = ^wr_data[31:NUM_SOURCES];

    assign rise   = irq_src & ~src_q;
    assign active = pending_q & enable_q & ~inservice_mask;
    assign w1c    = (wr_en && sel_pending) ? wr_data[NUM_SOURCES-1:0] : '0;

    // Hide the source currently being serviced from arbitration
    always_comb begin
        inservice_mask = '0;
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            inservice_mask[i] = (state_q == IN_SERVICE) && (active_id_q == ID_W'(i + 1));
        end
    end

    // Lowest set bit of active wins; 0 means nothing to report
    always_comb begin
        best_id = '0;
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (active[i]) begin
                best_id = ID_W'(i + 1);
            end
        end
    end

    assign claim_rd    = rd_en && sel_claim && (state_q == ASSERT) && (best_id != '0);
    assign complete_wr = wr_en && sel_claim && (state_q == IN_SERVICE) &&
                         (wr_data[ID_W-1:0] == active_id_q);

    // Edge sources: set beats clear; level sources follow the input
    always_comb begin
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            claim_clr[i] = claim_rd && (best_id == ID_W'(i + 1));
        end
        pending_d = (mode_q & (rise | (pending_q & ~w1c & ~claim_clr))) |
                    (~mode_q & irq_src);
    end

    // Next-state logic for the claim/complete handshake
    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        case (state_q)
            IDLE: begin
                if (active != '0) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (claim_rd) begin
                    state_d     = IN_SERVICE;
                    active_id_d = best_id;
                end else if (active == '0) begin
                    state_d = IDLE;
                end
            end
            IN_SERVICE: begin
                if (complete_wr) begin
                    state_d     = IDLE;
                    active_id_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                active_id_d = '0;
            end
        endcase
    end

    // Handshake state register; irq_out tracks the ASSERT state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            active_id_q <= '0;
            irq_out     <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_id_q <= active_id_d;
            irq_out     <= (state_d == ASSERT);
        end
    end

    // Source sampling and software-visible registers
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
        end else begin
            src_q     <= irq_src;
            pending_q <= pending_d;
            if (wr_en && sel_enable) begin
                enable_q <= wr_data[NUM_SOURCES-1:0];
            end
            if (wr_en && sel_mode) begin
                mode_q <= wr_data[NUM_SOURCES-1:0];
            end
        end
    end

    // Read mux returns pre-edge register state
    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            if (sel_pending) begin
                rd_data = 32'(pending_q);
            end else if (sel_enable) begin
                rd_data = 32'(enable_q);
            end else if (sel_mode) begin
                rd_data = 32'(mode_q);
            end else if (sel_claim) begin
                rd_data = (state_q == ASSERT) ? 32'(best_id) : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: directed handshake scenarios followed by random
// register traffic and source toggling, checked against a behavioural model.
module tb_irq_controller;

    localparam int unsigned N     = 8;
    localparam int unsigned NMASK = 32'hFF;
    localparam logic [31:0] A_P   = 32'h0;
    localparam logic [31:0] A_E   = 32'h4;
    localparam logic [31:0] A_M   = 32'h8;
    localparam logic [31:0] A_C   = 32'hC;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   address;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic [N-1:0]  irq_src;
    logic          irq_out;

    irq_controller #(.NUM_SOURCES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .irq_src (irq_src),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Stimulus state held between cycles
    logic         cur_rst = 1'b0;
    logic [N-1:0] cur_src = '0;
    logic [31:0]  obs_rd;
    logic         obs_irq;

    // Reference model: registers as plain integers plus "who is being served"
    int unsigned m_pend, m_en, m_md, m_prev, m_serv;
    bit          m_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_en = 0; m_md = 0; m_prev = 0; m_serv = 0; m_req = 0;
    endtask

    // One bus cycle: drive, sample mid-cycle, compare, then advance model past the edge
    task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd);
        int unsigned act, best, exp_rd, nxt, s, bitv, edge_i, clr;
        bit claim, complete;
        @(negedge clk);
        rst     = cur_rst;
        address = a;
        wr_en   = we;
        rd_en   = re;
        wr_data = wd;
        irq_src = cur_src;
        #1;
        obs_rd  = rd_data;
        obs_irq = irq_out;

        act = m_pend & m_en & NMASK;
        if (m_serv != 0) act = act & ~(32'd1 << (m_serv - 1));
        best = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (((act >> i) & 1) != 0) best = i + 1;
        end
        exp_rd = 0;
        if (re) begin
            if (a == A_P)      exp_rd = m_pend;
            else if (a == A_E) exp_rd = m_en;
            else if (a == A_M) exp_rd = m_md;
            else if (a == A_C) exp_rd = m_req ? best : 0;
        end
        check("rd_data", obs_rd, exp_rd);
        check("irq_out", {31'b0, obs_irq}, {31'b0, m_req});

        s = 32'(cur_src);
        if (cur_rst) begin
            model_reset();
        end else begin
            claim    = re && (a == A_C) && m_req && (best != 0);
            complete = we && (a == A_C) && (m_serv != 0) && ((wd & 32'h1F) == m_serv);
            nxt = 0;
            for (int i = 0; i < int'(N); i++) begin
                if (((m_md >> i) & 1) != 0) begin
                    edge_i = ((s >> i) & 1) & ~((m_prev >> i) & 1) & 1;
                    clr    = ((we && (a == A_P) && (((wd >> i) & 1) != 0)) ||
                              (claim && (best == i + 1))) ? 1 : 0;
                    bitv   = edge_i | (((m_pend >> i) & 1) & ~clr & 1);
                end else begin
                    bitv = (s >> i) & 1;
                end
                nxt |= bitv << i;
            end
            if (m_serv != 0) begin
                if (complete) m_serv = 0;
            end else if (m_req) begin
                if (claim) begin
                    m_serv = best;
                    m_req  = 0;
                end else if (act == 0) begin
                    m_req = 0;
                end
            end else if (act != 0) begin
                m_req = 1;
            end
            if (we && (a == A_E)) m_en = wd & NMASK;
            if (we && (a == A_M)) m_md = wd & NMASK;
            m_pend = nxt;
            m_prev = s;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    initial begin
        logic [31:0] ra, rdat;
        int unsigned pick;

        rst = 1'b1; address = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; irq_src = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // 1: reset values and unmapped read
        rd(A_P); check("t1_pend", obs_rd, 32'h0); check("t1_irq", {31'b0, obs_irq}, 32'h0);
        rd(A_E); check("t1_en", obs_rd, 32'h0);
        rd(A_M); check("t1_mode", obs_rd, 32'h0);
        rd(A_C); check("t1_claim", obs_rd, 32'h0);
        rd(32'h10); check("t1_unmapped", obs_rd, 32'h0);

        // 2: single edge source, claim and complete
        wr(A_E, 32'h1); wr(A_M, 32'h1);
        cur_src = 8'h01; idle();
        cur_src = 8'h00;
        rd(A_P); check("t2_pend", obs_rd, 32'h1); check("t2_irq_early", {31'b0, obs_irq}, 32'h0);
        rd(A_C); check("t2_irq", {31'b0, obs_irq}, 32'h1); check("t2_claim", obs_rd, 32'h1);
        rd(A_P); check("t2_pend_clr", obs_rd, 32'h0); check("t2_irq_svc", {31'b0, obs_irq}, 32'h0);
        wr(A_C, 32'h1);
        idle(); idle(); check("t2_irq_done", {31'b0, obs_irq}, 32'h0);

        // 3: two simultaneous edges, priority then the next one
        wr(A_E, 32'hFF); wr(A_M, 32'hFF);
        cur_src = 8'h28; idle();
        cur_src = 8'h00; idle();
        rd(A_C); check("t3_claim4", obs_rd, 32'h4);
        wr(A_C, 32'h4);
        idle();
        rd(A_C); check("t3_reassert", {31'b0, obs_irq}, 32'h1); check("t3_claim6", obs_rd, 32'h6);
        wr(A_C, 32'h6);

        // 4: level source reasserts while held, not after it drops
        wr(A_M, 32'h0); wr(A_E, 32'h2);
        cur_src = 8'h02; idle(); idle();
        rd(A_C); check("t4_claim2", obs_rd, 32'h2);
        wr(A_C, 32'h2);
        idle();
        rd(A_C); check("t4_reassert", {31'b0, obs_irq}, 32'h1); check("t4_claim2b", obs_rd, 32'h2);
        cur_src = 8'h00; idle();
        wr(A_C, 32'h2);
        idle(); check("t4_no_reassert", {31'b0, obs_irq}, 32'h0);
        rd(A_P); check("t4_pend", obs_rd, 32'h0);

        // 5: masked pending, late enable, W1C racing a new edge
        wr(A_M, 32'hFF); wr(A_E, 32'h0);
        cur_src = 8'h04; idle();
        cur_src = 8'h00;
        rd(A_P); check("t5_pend", obs_rd, 32'h4); check("t5_irq_masked", {31'b0, obs_irq}, 32'h0);
        wr(A_E, 32'h4);
        idle(); check("t5_irq_1cyc", {31'b0, obs_irq}, 32'h0);
        idle(); check("t5_irq_2cyc", {31'b0, obs_irq}, 32'h1);
        cur_src = 8'h04; wr(A_P, 32'h4);
        cur_src = 8'h00;
        rd(A_P); check("t5_set_wins", obs_rd, 32'h4);
        wr(A_P, 32'h4);
        idle(); idle(); check("t5_irq_drop", {31'b0, obs_irq}, 32'h0);

        // 6: mismatched complete ignored, then reset mid-service
        wr(A_E, 32'hFF);
        cur_src = 8'h01; idle();
        cur_src = 8'h00; idle();
        rd(A_C); check("t6_claim1", obs_rd, 32'h1);
        wr(A_C, 32'h3);
        rd(A_C); check("t6_svc_read", obs_rd, 32'h0);
        cur_src = 8'h02; idle();
        cur_src = 8'h00; idle(); idle();
        check("t6_still_svc", {31'b0, obs_irq}, 32'h0);
        cur_rst = 1'b1; idle();
        cur_rst = 1'b0;
        rd(A_P); check("t6_rst_pend", obs_rd, 32'h0); check("t6_rst_irq", {31'b0, obs_irq}, 32'h0);
        rd(A_E); check("t6_rst_en", obs_rd, 32'h0);
        rd(A_M); check("t6_rst_mode", obs_rd, 32'h0);
        rd(A_C); check("t6_rst_claim", obs_rd, 32'h0);

        // Random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            cur_rst = ($urandom_range(0, 199) == 0);
            cur_src = cur_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
            pick = $urandom_range(0, 6);
            case (pick)
                0: ra = A_P;
                1: ra = A_E;
                2: ra = A_M;
                3, 4: ra = A_C;
                5: ra = 32'h10;
                default: ra = $urandom;
            endcase
            rdat = (ra == A_C) ? 32'($urandom_range(0, 9)) : $urandom;
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), ra, rdat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
